// File: rtl/wave_shaper_if.sv
// Bus bundle between the DDS core / control side and the waveform shaper.
interface wave_shaper_if #(
  parameter int DW      = 8,
  parameter int PHASE_W = 32
);
  logic [DW-1:0]      dds_wave_i;
  logic               dds_wave_valid_i;
  logic [PHASE_W-1:0] dds_phase_i;
  logic               mode_trig_i;
  logic               mode_load_i;
  logic [2:0]         mode_i;
  logic [DW-1:0]      duty_i;
  logic [DW:0]        amp_i;
  logic [DW-1:0]      wave_data_o;
  logic               wave_data_valid_o;
  logic [2:0]         mode_o;
  logic               sw_pending_o;

  // Sample source and control side
  modport master (
    output dds_wave_i, dds_wave_valid_i, dds_phase_i,
    output mode_trig_i, mode_load_i, mode_i, duty_i, amp_i,
    input  wave_data_o, wave_data_valid_o, mode_o, sw_pending_o
  );

  // Shaper side
  modport slave (
    input  dds_wave_i, dds_wave_valid_i, dds_phase_i,
    input  mode_trig_i, mode_load_i, mode_i, duty_i, amp_i,
    output wave_data_o, wave_data_valid_o, mode_o, sw_pending_o
  );
endinterface

// File: rtl/wave_shaper.sv
// DDS waveform shaper: sine / triangle / saw / reverse saw / square selection,
// square duty, amplitude scaling, optionally phase-wrap aligned mode switching.
// Two-stage pipeline: shaped sample, then scaled sample.
module wave_shaper #(
  parameter int DW      = 8,
  parameter int PHASE_W = 32,
  parameter int TAP_MSB = 26,
  parameter bit SYNC_SW = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  wave_shaper_if.slave  bus
);

  typedef enum logic [2:0] {
    MODE_SIN  = 3'd0,
    MODE_TRI  = 3'd1,
    MODE_SAW  = 3'd2,
    MODE_RSAW = 3'd3,
    MODE_SQR  = 3'd4
  } wave_mode_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_ARMED = 1'b1
  } sw_state_e;

  localparam logic [DW:0]   UNITY   = {1'b1, {DW{1'b0}}};
  localparam logic [DW:0]   MID_EXT = {2'b01, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MID     = {1'b1, {(DW-1){1'b0}}};

  wave_mode_e       target_q;
  wave_mode_e       mode_q;
  wave_mode_e       eff_mode;
  sw_state_e        state_q;
  logic             prev_msb_q;

  logic [DW-1:0]    tap;
  logic [DW-1:0]    tri_v;
  logic             wrap;
  logic             qualify;
  logic             take_switch;
  logic [DW-1:0]    shaped;

  logic             v1_q;
  logic [DW-1:0]    raw_q;
  logic             valid_q;
  logic [DW-1:0]    data_q;

  logic [DW:0]          amp_eff;
  logic signed [DW:0]   s_val;
  logic signed [2*DW+2:0] prod;
  logic [DW-1:0]        scaled;

  logic unused_bits;

  assign tap   = bus.dds_phase_i[TAP_MSB -: DW];
  assign tri_v = {tap[DW-2:0], 1'b0};

  // Only the tap window of the phase and the middle bits of the product matter.
  assign unused_bits = ^{bus.dds_phase_i, prod[2*DW+2:2*DW], prod[DW-1:0]};

  // Wrap = tap MSB falling between consecutive valid samples.
  assign wrap        = prev_msb_q & ~tap[DW-1];
  assign qualify     = bus.dds_wave_valid_i & (SYNC_SW ? wrap : 1'b1);
  // The qualifying sample is itself shaped with the incoming mode.
  assign take_switch = (state_q == ST_ARMED) && qualify && (target_q != mode_q);
  assign eff_mode    = take_switch ? target_q : mode_q;

  // Target mode: load wins over trig; out-of-range load values are dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      target_q <= MODE_SIN;
    end else if (bus.mode_load_i) begin
      if (bus.mode_i <= 3'd4) begin
        target_q <= wave_mode_e'(bus.mode_i);
      end
    end else if (bus.mode_trig_i) begin
      target_q <= (target_q == MODE_SQR) ? MODE_SIN : wave_mode_e'(target_q + 3'd1);
    end
  end

  // Switch FSM: arm when target differs, commit on the qualifying sample.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_RUN;
      mode_q     <= MODE_SIN;
      prev_msb_q <= 1'b0;
    end else begin
      if (bus.dds_wave_valid_i) begin
        prev_msb_q <= tap[DW-1];
      end
      case (state_q)
        ST_RUN: begin
          if (target_q != mode_q) begin
            state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (target_q == mode_q) begin
            state_q <= ST_RUN;
          end else if (qualify) begin
            mode_q  <= target_q;
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Raw waveform for the mode in effect on this sample.
  always_comb begin
    shaped = '0;
    case (eff_mode)
      MODE_SIN:  shaped = {~bus.dds_wave_i[DW-1], bus.dds_wave_i[DW-2:0]};
      MODE_TRI:  shaped = tap[DW-1] ? ~tri_v : tri_v;
      MODE_SAW:  shaped = tap;
      MODE_RSAW: shaped = ~tap;
      MODE_SQR:  shaped = (tap < bus.duty_i) ? '1 : '0;
      default:   shaped = '0;
    endcase
  end

  // Stage 1: capture the shaped sample on each valid strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1_q  <= 1'b0;
      raw_q <= '0;
    end else begin
      v1_q <= bus.dds_wave_valid_i;
      if (bus.dds_wave_valid_i) begin
        raw_q <= shaped;
      end
    end
  end

  // Amplitude scaling about the midpoint; floor shift keeps results in range.
  always_comb begin
    amp_eff = (bus.amp_i > UNITY) ? UNITY : bus.amp_i;
    s_val   = $signed({1'b0, raw_q}) - $signed(MID_EXT);
    prod    = (2*DW+3)'(s_val) * (2*DW+3)'($signed({1'b0, amp_eff}));
    scaled  = MID + prod[2*DW-1:DW];
  end

  // Stage 2: register the scaled sample; data holds between strobes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= v1_q;
      if (v1_q) begin
        data_q <= scaled;
      end
    end
  end

  assign bus.wave_data_o       = data_q;
  assign bus.wave_data_valid_o = valid_q;
  assign bus.mode_o            = mode_q;
  assign bus.sw_pending_o      = (target_q != mode_q);

endmodule

// File: tb/tb_wave_shaper.sv
// Bench for wave_shaper: one immediate-switch and one wrap-aligned instance
// driven identically and checked every cycle against an arithmetic model.
module tb_wave_shaper;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wave_shaper_if #(.DW(DW), .PHASE_W(32)) bus0 ();
  wave_shaper_if #(.DW(DW), .PHASE_W(32)) bus1 ();

  wave_shaper #(.DW(DW), .PHASE_W(32), .TAP_MSB(26), .SYNC_SW(1'b0)) u_imm (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus0)
  );
  wave_shaper #(.DW(DW), .PHASE_W(32), .TAP_MSB(26), .SYNC_SW(1'b1)) u_sync (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cur_duty = 128;
  int cur_amp  = 256;

  // Reference state; index 0 = immediate instance, 1 = wrap-aligned instance.
  int m_mode [2];
  int m_tgt  [2];
  int m_prev;
  int s1_v;
  int s1_raw [2];
  int out_v;
  int out_d  [2];

  function automatic int shape(int mode, int tap, int wave, int duty);
    int sw;
    case (mode)
      0: begin sw = (wave >= 128) ? wave - 256 : wave; return sw + 128; end
      1: return (tap < 128) ? 2 * tap : 255 - 2 * (tap - 128);
      2: return tap;
      3: return 255 - tap;
      default: return (tap < duty) ? 255 : 0;
    endcase
  endfunction

  function automatic int scale(int raw, int amp);
    int a, p, q;
    a = (amp > 256) ? 256 : amp;
    p = (raw - 128) * a;
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return 128 + q;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_tgt[k] = 0; s1_raw[k] = 0; out_d[k] = 0;
    end
    m_prev = 0; s1_v = 0; out_v = 0;
  endtask

  task automatic check_all();
    chk("imm_valid",   {31'b0, bus0.wave_data_valid_o}, out_v);
    chk("imm_data",    {24'b0, bus0.wave_data_o},       out_d[0]);
    chk("imm_mode",    {29'b0, bus0.mode_o},            m_mode[0]);
    chk("imm_pending", {31'b0, bus0.sw_pending_o},      (m_tgt[0] != m_mode[0]) ? 1 : 0);
    chk("sync_valid",  {31'b0, bus1.wave_data_valid_o}, out_v);
    chk("sync_data",   {24'b0, bus1.wave_data_o},       out_d[1]);
    chk("sync_mode",   {29'b0, bus1.mode_o},            m_mode[1]);
    chk("sync_pending",{31'b0, bus1.sw_pending_o},      (m_tgt[1] != m_mode[1]) ? 1 : 0);
  endtask

  task automatic drive(input bit v, input int tap, input int wave,
                       input bit trig, input bit load, input int mval);
    logic [31:0] ph;
    logic [31:0] tv;
    ph = $urandom;
    tv = tap;
    ph[26:19] = tv[7:0];
    bus0.dds_wave_valid_i = v;     bus1.dds_wave_valid_i = v;
    bus0.dds_phase_i = ph;         bus1.dds_phase_i = ph;
    bus0.dds_wave_i = wave[7:0];   bus1.dds_wave_i = wave[7:0];
    bus0.mode_trig_i = trig;       bus1.mode_trig_i = trig;
    bus0.mode_load_i = load;       bus1.mode_load_i = load;
    bus0.mode_i = mval[2:0];       bus1.mode_i = mval[2:0];
    bus0.duty_i = cur_duty[7:0];   bus1.duty_i = cur_duty[7:0];
    bus0.amp_i = cur_amp[8:0];     bus1.amp_i = cur_amp[8:0];
  endtask

  // One clock: drive, advance the model, clock, compare.
  task automatic cyc(input bit v, input int tap, input int wave,
                     input bit trig, input bit load, input int mval);
    bit q;
    drive(v, tap, wave, trig, load, mval);
    if (s1_v != 0) begin
      out_d[0] = scale(s1_raw[0], cur_amp);
      out_d[1] = scale(s1_raw[1], cur_amp);
    end
    out_v = s1_v;
    if (v) begin
      for (int k = 0; k < 2; k++) begin
        q = (k == 0) ? 1'b1 : (m_prev == 1 && tap < 128);
        if (q && m_tgt[k] != m_mode[k]) m_mode[k] = m_tgt[k];
        s1_raw[k] = shape(m_mode[k], tap, wave, cur_duty);
      end
      m_prev = (tap >= 128) ? 1 : 0;
    end
    s1_v = v ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      if (load) begin
        if (mval <= 4) m_tgt[k] = mval;
      end else if (trig) begin
        m_tgt[k] = (m_tgt[k] + 1) % 5;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic samp(input int tap);
    cyc(1'b1, tap, $urandom_range(0, 255), 1'b0, 1'b0, 0);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 0, 1'b0, 1'b0, 0);
  endtask

  // Control pulse followed by a quiet cycle so the switch logic can arm.
  task automatic ctl(input bit trig, input bit load, input int mval);
    cyc(1'b0, 0, 0, trig, load, mval);
    idle();
  endtask

  initial begin
    model_reset();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    idle();

    // Saw at unity gain reproduces the tap two cycles later.
    cur_amp = 256;
    ctl(1'b0, 1'b1, 2);
    for (int t = 0; t < 256; t++) samp(t);
    for (int t = 0; t < 256; t++) samp(t);
    idle(); idle();

    // Trig walk and out-of-range load.
    for (int i = 0; i < 5; i++) begin
      ctl(1'b1, 1'b0, 0);
      samp($urandom_range(0, 255));
      idle(); idle();
    end
    ctl(1'b0, 1'b1, 6);
    samp(30); idle(); idle();

    // Wrap-aligned switch: arm at tap 100, commit on MSB 1 -> 0.
    samp(100);
    ctl(1'b1, 1'b0, 0);
    samp(150); samp(200); samp(250); samp(5); samp(60);
    idle(); idle();

    // Square with duty 64, then duty 0.
    ctl(1'b0, 1'b1, 4);
    cur_duty = 64;
    for (int t = 0; t < 256; t++) samp(t);
    for (int t = 0; t < 256; t += 3) samp(t);
    cur_duty = 0;
    for (int t = 0; t < 256; t += 5) samp(t);
    idle(); idle();

    // Amplitude scaling points and clamp.
    ctl(1'b0, 1'b1, 2);
    samp(200); samp(10);
    cur_amp = 128;
    samp(255); samp(0); idle(); idle();
    cur_amp = 300;
    samp(255); samp(0); samp(77); idle(); idle();
    cur_amp = 0;
    samp(255); samp(3); idle(); idle();

    // Randomised traffic with occasional control pulses.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) cur_amp = $urandom_range(0, 511);
      if ($urandom_range(0, 9) == 0) cur_duty = $urandom_range(0, 255);
      case ($urandom_range(0, 19))
        0: ctl(1'b1, 1'b0, 0);
        1: ctl(1'b0, 1'b1, $urandom_range(0, 7));
        2: ctl(1'b1, 1'b1, $urandom_range(0, 7));
        default: cyc($urandom_range(0, 9) < 7, $urandom_range(0, 255),
                     $urandom_range(0, 255), 1'b0, 1'b0, 0);
      endcase
    end

    // Reset with two samples in flight.
    cur_amp = 256;
    ctl(1'b1, 1'b0, 0);
    samp(40); samp(90);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle();
    samp(123); idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
